// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue stage: ALU op codes,
// RV32 opcode/funct fields and the decoder result record.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLL = 4'b0101,
        ALU_SRL = 4'b0110
    } alu_op_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef struct packed {
        logic    legal;
        alu_op_e op;
        logic    use_imm;
    } dec_t;

endpackage

// File: rtl/alu_issue_decoder.sv
// Combinational RV32 R/I-type ALU decoder: classifies the instruction,
// selects the ALU op, splits out register fields and sign-extends the immediate.
module alu_issue_decoder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      i_instr,
    output dec_t             o_dec,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [4:0]       o_rd,
    output logic [WIDTH-1:0] o_imm
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_is_r;
    logic       w_is_i;
    logic       w_f_legal;

    assign w_opc  = i_instr[6:0];
    assign w_f3   = i_instr[14:12];
    assign w_f7   = i_instr[31:25];
    assign w_is_r = (w_opc == OPC_OP);
    assign w_is_i = (w_opc == OPC_OPIMM);

    assign o_rd  = i_instr[11:7];
    assign o_rs1 = i_instr[19:15];
    assign o_rs2 = i_instr[24:20];
    assign o_imm = {{(WIDTH-12){i_instr[31]}}, i_instr[31:20]};

    // Map funct3/funct7 to an ALU op and decide legality for the two formats
    always_comb begin
        o_dec     = '{legal: 1'b0, op: ALU_ADD, use_imm: 1'b0};
        w_f_legal = 1'b0;
        case (w_f3)
            F3_ADD: begin
                o_dec.op  = (w_is_r && (w_f7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
                w_f_legal = w_is_i || (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
            end
            F3_AND: begin
                o_dec.op  = ALU_AND;
                w_f_legal = w_is_i || (w_f7 == F7_ZERO);
            end
            F3_OR: begin
                o_dec.op  = ALU_OR;
                w_f_legal = w_is_i || (w_f7 == F7_ZERO);
            end
            F3_XOR: begin
                o_dec.op  = ALU_XOR;
                w_f_legal = w_is_i || (w_f7 == F7_ZERO);
            end
            // Shift-immediates reuse imm[11:5] as funct7; SRA/SRAI stay illegal
            F3_SLL: begin
                o_dec.op  = ALU_SLL;
                w_f_legal = (w_f7 == F7_ZERO);
            end
            F3_SRL: begin
                o_dec.op  = ALU_SRL;
                w_f_legal = (w_f7 == F7_ZERO);
            end
            default: begin
                o_dec.op  = ALU_ADD;
                w_f_legal = 1'b0;
            end
        endcase
        o_dec.legal   = w_f_legal && (w_is_r || w_is_i);
        o_dec.use_imm = w_is_i;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of a registered ALU: decodes, selects/forwards operands,
// registers ALU controls, tags the writeback and counts issued/rejected instructions.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_rs1_val,
    input  logic [WIDTH-1:0] in_rs2_val,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic             illegal_valid,
    output logic [31:0]      illegal_instr,
    output logic [CNT_W-1:0] issue_count,
    output logic [CNT_W-1:0] illegal_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    dec_t             w_dec;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [4:0]       w_rd;
    logic [WIDTH-1:0] w_imm;
    logic             w_accept;
    logic             w_reject;
    logic             w_ex_a;
    logic             w_ex_b;
    logic             w_wb_a;
    logic             w_wb_b;
    logic [WIDTH-1:0] w_cap_a;
    logic [WIDTH-1:0] w_cap_b;

    logic             r_iss_valid;
    logic [4:0]       r_iss_rd;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    alu_op_e          r_ctrl;
    logic             r_fwd_a;
    logic             r_fwd_b;
    logic             r_wb_valid;
    logic [4:0]       r_wb_rd;
    logic             r_ill_valid;
    logic [31:0]      r_ill_instr;
    logic [CNT_W-1:0] r_iss_cnt;
    logic [CNT_W-1:0] r_ill_cnt;

    alu_issue_decoder #(.WIDTH(WIDTH)) u_dec (
        .i_instr (in_instr),
        .o_dec   (w_dec),
        .o_rs1   (w_rs1),
        .o_rs2   (w_rs2),
        .o_rd    (w_rd),
        .o_imm   (w_imm)
    );

    assign w_accept = in_valid && w_dec.legal;
    assign w_reject = in_valid && !w_dec.legal;

    // Forward detection: the instruction now in issue (EX) wins over the one in WB; x0 never matches
    always_comb begin
        w_ex_a  = r_iss_valid && (r_iss_rd == w_rs1) && (w_rs1 != 5'd0);
        w_wb_a  = r_wb_valid && (r_wb_rd == w_rs1) && (w_rs1 != 5'd0) && !w_ex_a;
        w_cap_a = w_wb_a ? alu_result : in_rs1_val;
        if (w_dec.use_imm) begin
            w_ex_b  = 1'b0;
            w_wb_b  = 1'b0;
            w_cap_b = w_imm;
        end else begin
            w_ex_b  = r_iss_valid && (r_iss_rd == w_rs2) && (w_rs2 != 5'd0);
            w_wb_b  = r_wb_valid && (r_wb_rd == w_rs2) && (w_rs2 != 5'd0) && !w_ex_b;
            w_cap_b = w_wb_b ? alu_result : in_rs2_val;
        end
    end

    // Issue register: capture operands/control on a legal accept, otherwise insert a zeroed bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_valid <= 1'b0;
            r_iss_rd    <= 5'd0;
            r_opa       <= {WIDTH{1'b0}};
            r_opb       <= {WIDTH{1'b0}};
            r_ctrl      <= ALU_ADD;
            r_fwd_a     <= 1'b0;
            r_fwd_b     <= 1'b0;
        end else if (w_accept) begin
            r_iss_valid <= 1'b1;
            r_iss_rd    <= w_rd;
            r_opa       <= w_cap_a;
            r_opb       <= w_cap_b;
            r_ctrl      <= w_dec.op;
            r_fwd_a     <= w_ex_a;
            r_fwd_b     <= w_ex_b;
        end else begin
            r_iss_valid <= 1'b0;
            r_iss_rd    <= 5'd0;
            r_opa       <= {WIDTH{1'b0}};
            r_opb       <= {WIDTH{1'b0}};
            r_ctrl      <= ALU_ADD;
            r_fwd_a     <= 1'b0;
            r_fwd_b     <= 1'b0;
        end
    end

    // Writeback tag follows the issue register by one cycle, lining up with the ALU's registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
        end else begin
            r_wb_valid <= r_iss_valid;
            r_wb_rd    <= r_iss_rd;
        end
    end

    // Reject reporting: one-cycle pulse, offending word held until the next reject
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ill_valid <= 1'b0;
            r_ill_instr <= 32'd0;
        end else if (w_reject) begin
            r_ill_valid <= 1'b1;
            r_ill_instr <= in_instr;
        end else begin
            r_ill_valid <= 1'b0;
            r_ill_instr <= r_ill_instr;
        end
    end

    // Saturating issue/reject counters, at most one step per cycle each
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_cnt <= {CNT_W{1'b0}};
            r_ill_cnt <= {CNT_W{1'b0}};
        end else begin
            r_iss_cnt <= w_accept ? sat_inc(r_iss_cnt) : r_iss_cnt;
            r_ill_cnt <= w_reject ? sat_inc(r_ill_cnt) : r_ill_cnt;
        end
    end

    assign in_ready      = !rst;
    assign operand_a     = r_fwd_a ? alu_result : r_opa;
    assign operand_b     = r_fwd_b ? alu_result : r_opb;
    assign alu_ctrl      = r_ctrl;
    assign wb_valid      = r_wb_valid;
    assign wb_rd         = r_wb_rd;
    assign illegal_valid = r_ill_valid;
    assign illegal_instr = r_ill_instr;
    assign issue_count   = r_iss_cnt;
    assign illegal_count = r_ill_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: surrounds the stage with a registered ALU and a
// register file, drives directed and random instruction streams, and scores
// writebacks/rejects against an architectural reference model.
module tb_alu_issue_stage;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [W-1:0]  in_rs1_val;
    logic [W-1:0]  in_rs2_val;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  alu_result;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic          illegal_valid;
    logic [31:0]   illegal_instr;
    logic [15:0]   issue_count;
    logic [15:0]   illegal_count;

    logic          s_in_ready;
    logic [W-1:0]  s_operand_a;
    logic [W-1:0]  s_operand_b;
    logic [3:0]    s_alu_ctrl;
    logic          s_wb_valid;
    logic [4:0]    s_wb_rd;
    logic          s_illegal_valid;
    logic [31:0]   s_illegal_instr;
    logic [1:0]    s_issue_count;
    logic [1:0]    s_illegal_count;

    alu_issue_stage #(.WIDTH(W), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .operand_a(operand_a), .operand_b(operand_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .illegal_valid(illegal_valid), .illegal_instr(illegal_instr),
        .issue_count(issue_count), .illegal_count(illegal_count)
    );

    // Narrow-counter copy, fed the same stream, to observe saturation
    alu_issue_stage #(.WIDTH(W), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .operand_a(s_operand_a), .operand_b(s_operand_b), .alu_ctrl(s_alu_ctrl),
        .alu_result(alu_result), .wb_valid(s_wb_valid), .wb_rd(s_wb_rd),
        .illegal_valid(s_illegal_valid), .illegal_instr(s_illegal_instr),
        .issue_count(s_issue_count), .illegal_count(s_illegal_count)
    );

    typedef struct packed {
        logic [4:0]   rd;
        logic [W-1:0] val;
    } wb_t;

    wb_t          exp_wb[$];
    logic [31:0]  exp_ill[$];
    logic [W-1:0] ref_regs [32];
    logic [W-1:0] rf [32];
    int           checks;
    int           errors;
    int           n_iss;
    int           n_ill;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment ALU (registered)
    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Registered ALU fed by the stage
    always @(posedge clk or posedge rst) begin
        if (rst) alu_result <= 32'd0;
        else     alu_result <= alu_f(operand_a, operand_b, alu_ctrl);
    end

    // Register file written at the end of the WB cycle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (wb_valid && (wb_rd != 5'd0)) begin
            rf[wb_rd] <= alu_result;
        end
    end

    // Architectural reference: returns legality and the value the instruction should produce
    function automatic bit ref_exec(input logic [31:0] instr, output logic [W-1:0] res);
        logic [6:0]   opc;
        logic [2:0]   f3;
        logic [6:0]   f7;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           is_r;
        bit           is_i;
        opc  = instr[6:0];
        f3   = instr[14:12];
        f7   = instr[31:25];
        is_r = (opc == 7'b0110011);
        is_i = (opc == 7'b0010011);
        a    = ref_regs[instr[19:15]];
        b    = is_r ? ref_regs[instr[24:20]] : {{20{instr[31]}}, instr[31:20]};
        res  = 32'd0;
        if (!is_r && !is_i) return 1'b0;
        case (f3)
            3'd0: begin
                if (is_i || f7 == 7'd0) begin res = a + b; return 1'b1; end
                if (f7 == 7'h20)        begin res = a - b; return 1'b1; end
                return 1'b0;
            end
            3'd7: begin res = a & b; return is_i || f7 == 7'd0; end
            3'd6: begin res = a | b; return is_i || f7 == 7'd0; end
            3'd4: begin res = a ^ b; return is_i || f7 == 7'd0; end
            3'd1: begin res = a << b[4:0]; return f7 == 7'd0; end
            3'd5: begin res = a >> b[4:0]; return f7 == 7'd0; end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [31:0] instr, input bit track);
        logic [W-1:0] r;
        bit           ok;
        @(posedge clk); #1;
        in_valid   = 1'b1;
        in_instr   = instr;
        in_rs1_val = rf[instr[19:15]];
        in_rs2_val = rf[instr[24:20]];
        if (track) begin
            ok = ref_exec(instr, r);
            if (ok) begin
                exp_wb.push_back(wb_t'{rd: instr[11:7], val: r});
                if (instr[11:7] != 5'd0) ref_regs[instr[11:7]] = r;
                n_iss++;
            end else begin
                exp_ill.push_back(instr);
                n_ill++;
            end
        end
    endtask

    task automatic bubble();
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_instr   = $urandom;
        in_rs1_val = $urandom;
        in_rs2_val = $urandom;
    endtask

    function automatic logic [6:0] pick_f7();
        int p;
        p = $urandom_range(0, 9);
        if (p < 7)  return 7'd0;
        if (p < 9)  return 7'h20;
        return 7'($urandom);
    endfunction

    initial begin
        wb_t          e;
        logic [31:0]  w;
        logic [31:0]  instr;
        int           p;
        checks = 0; errors = 0; n_iss = 0; n_ill = 0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_rs1_val = 32'd0; in_rs2_val = 32'd0;

        // Scoreboard monitor: pops one expectation per observed writeback or reject
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (wb_valid) begin
                        checks++;
                        if (exp_wb.size() == 0) begin
                            errors++;
                            $display("FAIL wb_unexpected: got rd=%0d result=%h expected no writeback", wb_rd, alu_result);
                        end else begin
                            e = exp_wb.pop_front();
                            if (wb_rd !== e.rd || alu_result !== e.val) begin
                                errors++;
                                $display("FAIL wb_result: got rd=%0d result=%h expected rd=%0d result=%h",
                                         wb_rd, alu_result, e.rd, e.val);
                            end
                        end
                    end
                    if (illegal_valid) begin
                        checks++;
                        if (exp_ill.size() == 0) begin
                            errors++;
                            $display("FAIL illegal_unexpected: got word %h expected no reject", illegal_instr);
                        end else begin
                            w = exp_ill.pop_front();
                            if (illegal_instr !== w) begin
                                errors++;
                                $display("FAIL illegal_instr: got %h expected %h", illegal_instr, w);
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("rst_operand_a", operand_a, 32'd0);
        chk("rst_operand_b", operand_b, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_issue_count", {16'd0, issue_count}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, 32'd1);

        // Test 1: reset with two instructions in flight
        send(i_type(12'd3, 5'd0, 3'd0, 5'd1), 1'b0);
        send(i_type(12'd4, 5'd0, 3'd0, 5'd2), 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("midrst_issue_count", {16'd0, issue_count}, 32'd0);
        chk("midrst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        n_iss = 0; n_ill = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        end

        // Test 2: EX forward to both operands
        send(i_type(12'd5, 5'd0, 3'd0, 5'd1), 1'b1);
        send(r_type(7'd0, 5'd1, 5'd1, 3'd0, 5'd2), 1'b1);
        bubble();
        @(negedge clk);
        chk("ex_fwd_a", operand_a, 32'd5);
        chk("ex_fwd_b", operand_b, 32'd5);
        repeat (3) bubble();

        // Test 3: WB forward across a bubble
        send(i_type(12'd7, 5'd0, 3'd0, 5'd3), 1'b1);
        bubble();
        send(r_type(7'h20, 5'd0, 5'd3, 3'd0, 5'd4), 1'b1);
        chk("wb_fwd_rs1_val", in_rs1_val, 32'd0);
        bubble();
        @(negedge clk);
        chk("wb_fwd_a", operand_a, 32'd7);
        chk("wb_fwd_ctrl", {28'd0, alu_ctrl}, 32'd1);
        repeat (3) bubble();

        // Test 4: SRAI is rejected
        send(i_type({7'h20, 5'd3}, 5'd1, 3'd5, 5'd6), 1'b1);
        repeat (3) bubble();
        @(negedge clk);
        chk("illegal_count", {16'd0, illegal_count}, 32'(n_ill));
        chk("issue_count_after_ill", {16'd0, issue_count}, 32'(n_iss));

        // Test 5: all-ones immediate, and an x0 producer never forwards
        send(i_type(12'hFFF, 5'd0, 3'd0, 5'd5), 1'b1);
        bubble();
        @(negedge clk);
        chk("imm_sext", operand_b, 32'hFFFF_FFFF);
        send(i_type(12'd9, 5'd0, 3'd0, 5'd0), 1'b1);
        send(r_type(7'd0, 5'd0, 5'd0, 3'd0, 5'd7), 1'b1);
        bubble();
        @(negedge clk);
        chk("x0_nofwd_a", operand_a, 32'd0);
        chk("x0_nofwd_b", operand_b, 32'd0);
        repeat (3) bubble();

        // Random stream with dense register reuse
        for (int k = 0; k < 400; k++) begin
            p = $urandom_range(0, 9);
            if (p < 2) begin
                bubble();
            end else begin
                instr = {pick_f7(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         3'($urandom), 5'($urandom_range(0, 7)), 7'b0};
                p = $urandom_range(0, 19);
                if (p < 9)       instr[6:0] = 7'b0110011;
                else if (p < 18) instr[6:0] = 7'b0010011;
                else             instr[6:0] = 7'($urandom);
                send(instr, 1'b1);
            end
        end
        repeat (4) bubble();

        // Drain with a bounded wait
        for (int i = 0; i < 20 && (exp_wb.size() != 0 || exp_ill.size() != 0); i++) @(negedge clk);
        chk("drain_wb", 32'(exp_wb.size()), 32'd0);
        chk("drain_ill", 32'(exp_ill.size()), 32'd0);

        // Final counters, including the saturating narrow copy
        @(negedge clk);
        chk("final_issue_count", {16'd0, issue_count}, 32'(n_iss));
        chk("final_illegal_count", {16'd0, illegal_count}, 32'(n_ill));
        chk("sat_issue_count", {30'd0, s_issue_count}, (n_iss > 3) ? 32'd3 : 32'(n_iss));
        chk("sat_illegal_count", {30'd0, s_illegal_count}, (n_ill > 3) ? 32'd3 : 32'(n_ill));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
